// File: rtl/sram_arbiter.sv
// Three-port arbiter and timing sequencer for the external async 8-bit SRAM.
// Define SRAM_ARB_RR_EN for CPU/DMA round-robin; default is fixed priority.
module sram_arbiter #(
   parameter int AW          = 21,
   parameter int DW          = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          clk_chipset,
   input  logic          reset_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] SRAM_ADDR,
   inout  wire  [DW-1:0] SRAM_DATA,
   output logic          SRAM_WE_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WS,
      S_WP,
      S_WH,
      S_DONE
   } state_t;

   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
   localparam logic [3:0] LP_WP   = 4'(WAIT_CYCLES - 1);

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_nxt;
   logic          w_load;
   logic [2:0]    w_gnt;
   logic [2:0]    r_own;
   logic [2:0]    r_ack;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] w_wdata;
   logic [DW-1:0] r_rdata;
   logic          r_we;
   logic          w_we;
   logic          r_we_n;
   logic          r_drive;

   // Grant vector is one-hot {dma, cpu, vid}; video always wins.
`ifdef SRAM_ARB_RR_EN
   logic r_rr;

   always_comb begin
      w_gnt = 3'b000;
      if (vid_req)
         w_gnt = 3'b001;
      else if (cpu_req && dma_req)
         w_gnt = r_rr ? 3'b100 : 3'b010;
      else if (cpu_req)
         w_gnt = 3'b010;
      else if (dma_req)
         w_gnt = 3'b100;
   end

   always_ff @(posedge clk_chipset or negedge reset_n) begin
      if (!reset_n)
         r_rr <= 1'b0;
      else if (w_load && !w_gnt[0])
         r_rr <= w_gnt[1];
   end
`else
   always_comb begin
      w_gnt = 3'b000;
      if (vid_req)
         w_gnt = 3'b001;
      else if (cpu_req)
         w_gnt = 3'b010;
      else if (dma_req)
         w_gnt = 3'b100;
   end
`endif

   always_comb begin
      w_addr  = dma_addr;
      w_wdata = dma_wdata;
      w_we    = dma_we;
      if (w_gnt[0]) begin
         w_addr  = vid_addr;
         w_wdata = '0;
         w_we    = 1'b0;
      end else if (w_gnt[1]) begin
         w_addr  = cpu_addr;
         w_wdata = cpu_wdata;
         w_we    = cpu_we;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      w_load    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (|w_gnt) begin
               w_load    = 1'b1;
               w_cnt_nxt = LP_WAIT;
               w_next    = w_we ? S_WS : S_RD;
            end
         end
         S_RD: begin
            if (r_cnt == 4'd0)
               w_next = S_DONE;
            else
               w_cnt_nxt = r_cnt - 4'd1;
         end
         S_WS: begin
            w_next    = S_WP;
            w_cnt_nxt = LP_WP;
         end
         S_WP: begin
            if (r_cnt == 4'd0)
               w_next = S_WH;
            else
               w_cnt_nxt = r_cnt - 4'd1;
         end
         S_WH:    w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_chipset or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_own   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         if (w_load) begin
            r_own   <= w_gnt;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_we    <= w_we;
         end
      end
   end

   // Pin controls are registered from next state so WE_n never glitches.
   always_ff @(posedge clk_chipset or negedge reset_n) begin
      if (!reset_n) begin
         r_we_n  <= 1'b1;
         r_drive <= 1'b0;
         r_ack   <= '0;
         r_rdata <= '0;
      end else begin
         r_we_n  <= (w_next != S_WP);
         r_drive <= (w_next == S_WS) || (w_next == S_WP) ||
                    (w_next == S_WH);
         r_ack   <= (w_next == S_DONE) ? r_own : 3'b000;
         if (r_state == S_RD && r_cnt == 4'd0 && !r_we)
            r_rdata <= SRAM_DATA;
      end
   end

   assign SRAM_ADDR = r_addr;
   assign SRAM_WE_n = r_we_n;
   assign SRAM_DATA = r_drive ? r_wdata : {DW{1'bz}};
   assign rdata     = r_rdata;
   assign busy      = (r_state != S_IDLE);
   assign vid_ack   = r_ack[0];
   assign cpu_ack   = r_ack[1];
   assign dma_ack   = r_ack[2];

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: main DUT at WAIT_CYCLES=2,
// plus two read-only instances at WAIT_CYCLES=1 and 15.
module tb_sram_arbiter;

   localparam int AW = 21;
   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic          vid_req, cpu_req, cpu_we, dma_req, dma_we;
   logic [AW-1:0] vid_addr, cpu_addr, dma_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata;
   logic          vid_ack, cpu_ack, dma_ack, busy, SRAM_WE_n;
   logic [DW-1:0] rdata;
   logic [AW-1:0] SRAM_ADDR;
   wire  [DW-1:0] SRAM_DATA;

   logic          tb_drv_en, tb_rd_mode;
   logic [DW-1:0] tb_drv_val;
   int            wr_cycles = 0;
   logic [AW-1:0] last_waddr = '0;
   logic [DW-1:0] last_wdata = '0;

   int n_vec = 0;
   int n_bad = 0;

   function automatic logic [7:0] rd_val(input logic [AW-1:0] a);
      case (a)
         21'h1ABCD: rd_val = 8'h5A;
         21'h00020: rd_val = 8'h11;
         21'h00030: rd_val = 8'h33;
         default:   rd_val = 8'hEE;
      endcase
   endfunction

   assign SRAM_DATA = tb_drv_en ?
      (tb_rd_mode ? rd_val(SRAM_ADDR) : tb_drv_val) : 8'hzz;

   // SRAM model: every edge with WE_n low stores the bus
   always @(posedge clk) begin
      if (SRAM_WE_n == 1'b0) begin
         wr_cycles  <= wr_cycles + 1;
         last_waddr <= SRAM_ADDR;
         last_wdata <= SRAM_DATA;
      end
   end

   sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(2)) u_dut (
      .clk_chipset(clk),     .reset_n(reset_n),
      .vid_req(vid_req),     .vid_addr(vid_addr),   .vid_ack(vid_ack),
      .cpu_req(cpu_req),     .cpu_we(cpu_we),       .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req),     .dma_we(dma_we),       .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_ack(dma_ack),
      .rdata(rdata),         .busy(busy),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DATA(SRAM_DATA), .SRAM_WE_n(SRAM_WE_n)
   );

   logic          aux_req;
   logic [AW-1:0] aux_addr = 21'h00777;
   logic          a1_vack, a1_cack, a1_dack, a1_busy, a1_wen;
   logic          a2_vack, a2_cack, a2_dack, a2_busy, a2_wen;
   logic [DW-1:0] a1_rdata, a2_rdata;
   logic [AW-1:0] a1_addr, a2_addr;
   wire  [DW-1:0] a1_data, a2_data;
   assign a1_data = 8'h3C;
   assign a2_data = 8'hE1;

   sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(1)) u_w1 (
      .clk_chipset(clk),   .reset_n(reset_n),
      .vid_req(1'b0),      .vid_addr('0),       .vid_ack(a1_vack),
      .cpu_req(aux_req),   .cpu_we(1'b0),       .cpu_addr(aux_addr),
      .cpu_wdata('0),      .cpu_ack(a1_cack),
      .dma_req(1'b0),      .dma_we(1'b0),       .dma_addr('0),
      .dma_wdata('0),      .dma_ack(a1_dack),
      .rdata(a1_rdata),    .busy(a1_busy),
      .SRAM_ADDR(a1_addr), .SRAM_DATA(a1_data), .SRAM_WE_n(a1_wen)
   );

   sram_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(15)) u_w15 (
      .clk_chipset(clk),   .reset_n(reset_n),
      .vid_req(1'b0),      .vid_addr('0),       .vid_ack(a2_vack),
      .cpu_req(aux_req),   .cpu_we(1'b0),       .cpu_addr(aux_addr),
      .cpu_wdata('0),      .cpu_ack(a2_cack),
      .dma_req(1'b0),      .dma_we(1'b0),       .dma_addr('0),
      .dma_wdata('0),      .dma_ack(a2_dack),
      .rdata(a2_rdata),    .busy(a2_busy),
      .SRAM_ADDR(a2_addr), .SRAM_DATA(a2_data), .SRAM_WE_n(a2_wen)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic cpu_read_1abcd(input string tag);
      tb_rd_mode = 1'b1;
      tb_drv_en  = 1'b1;
      cpu_req    = 1'b1;
      cpu_we     = 1'b0;
      cpu_addr   = 21'h1ABCD;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("%s addr c%0d", tag, c), 32'(SRAM_ADDR), 32'h1ABCD);
         chk($sformatf("%s wen c%0d", tag, c), 32'(SRAM_WE_n), 32'd1);
         chk($sformatf("%s ack c%0d", tag, c), 32'(cpu_ack),
             32'(c == 4));
         if (c == 4) begin
            chk({tag, " rdata"}, 32'(rdata), 32'h5A);
            cpu_req = 1'b0;
         end
      end
      tick();
      chk({tag, " idle busy"}, 32'(busy), 32'd0);
   endtask

   int order[$];
   int ack_cyc[$];
   int n_multi;
   int wr_base;
   int a1_cyc[$];
   int a2_cyc[$];
   int busy_bad;
   logic p1, p2;
   int exp_ord[4];

   initial begin
      reset_n   = 1'b0;
      vid_req   = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
      cpu_we    = 1'b0; dma_we  = 1'b0;
      vid_addr  = '0;   cpu_addr = '0;  dma_addr = '0;
      cpu_wdata = '0;   dma_wdata = '0;
      aux_req   = 1'b0;
      tb_drv_en = 1'b1; tb_rd_mode = 1'b0; tb_drv_val = 8'hA5;
      tick();
      tick();
      chk("rst wen", 32'(SRAM_WE_n), 32'd1);
      chk("rst addr", 32'(SRAM_ADDR), 32'd0);
      chk("rst rdata", 32'(rdata), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst acks", 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
      chk("rst bus z", 32'(SRAM_DATA), 32'hA5);
      reset_n = 1'b1;
      tick();

      cpu_read_1abcd("rd");

      // write 0xC3 to 0x10; bench drives 0xA5 only where the DUT must be Z
      tb_drv_en = 1'b0;
      tb_rd_mode = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 21'h00010; cpu_wdata = 8'hC3;
      wr_base = wr_cycles;
      for (int c = 1; c <= 5; c++) begin
         tick();
         tb_drv_en = (c == 5);
         #1;
         chk($sformatf("wr bus c%0d", c), 32'(SRAM_DATA),
             (c == 5) ? 32'hA5 : 32'hC3);
         chk($sformatf("wr wen c%0d", c), 32'(SRAM_WE_n),
             (c == 2 || c == 3) ? 32'd0 : 32'd1);
         chk($sformatf("wr ack c%0d", c), 32'(cpu_ack), 32'(c == 5));
         chk($sformatf("wr busy c%0d", c), 32'(busy), 32'd1);
         if (c == 5) cpu_req = 1'b0;
      end
      chk("wr pulse len", 32'(wr_cycles - wr_base), 32'd2);
      chk("wr mem addr", 32'(last_waddr), 32'h10);
      chk("wr mem data", 32'(last_wdata), 32'hC3);
      chk("wr rdata kept", 32'(rdata), 32'h5A);
      tick();

      // three simultaneous requests
      tb_rd_mode = 1'b1;
      tb_drv_en  = 1'b1;
      vid_req = 1'b1; vid_addr = 21'h00020;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 21'h1ABCD;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 21'h00030;
      n_multi = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if ($countones({vid_ack, cpu_ack, dma_ack}) > 1) n_multi++;
         if (vid_ack) begin
            order.push_back(0); ack_cyc.push_back(c);
            chk("pri vid rdata", 32'(rdata), 32'h11);
            vid_req = 1'b0;
         end else if (cpu_ack) begin
            order.push_back(1); ack_cyc.push_back(c);
            chk("pri cpu rdata", 32'(rdata), 32'h5A);
         end else if (dma_ack) begin
            order.push_back(2); ack_cyc.push_back(c);
            chk("pri dma rdata", 32'(rdata), 32'h33);
            dma_req = 1'b0;
         end
         if (order.size() >= 4) begin
            cpu_req = 1'b0;
            dma_req = 1'b0;
         end
      end
      chk("pri multi ack", 32'(n_multi), 32'd0);
      chk("pri grants", 32'(order.size()), 32'd4);
`ifdef SRAM_ARB_RR_EN
      exp_ord = '{0, 1, 2, 1};
`else
      exp_ord = '{0, 1, 1, 1};
`endif
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("pri order %0d", i),
             (i < order.size()) ? 32'(order[i]) : 32'd99,
             32'(exp_ord[i]));
         chk($sformatf("pri cycle %0d", i),
             (i < ack_cyc.size()) ? 32'(ack_cyc[i]) : 32'd99,
             32'(4 + 5 * i));
      end
      chk("pri end idle", 32'(busy), 32'd0);

      // async reset in the middle of the write pulse
      tb_drv_en = 1'b0;
      tb_rd_mode = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1;
      cpu_addr = 21'h00040; cpu_wdata = 8'h77;
      wr_base = wr_cycles;
      tick();
      chk("ar ws wen", 32'(SRAM_WE_n), 32'd1);
      tick();
      chk("ar wp wen", 32'(SRAM_WE_n), 32'd0);
      #1 reset_n = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk("ar wen", 32'(SRAM_WE_n), 32'd1);
      chk("ar busy", 32'(busy), 32'd0);
      chk("ar addr", 32'(SRAM_ADDR), 32'd0);
      chk("ar rdata", 32'(rdata), 32'd0);
      tb_drv_en = 1'b1; tb_drv_val = 8'hA5;
      #1;
      chk("ar bus z", 32'(SRAM_DATA), 32'hA5);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("ar noack %0d", c),
             32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
      end
      chk("ar no write", 32'(wr_cycles - wr_base), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("ar post busy", 32'(busy), 32'd0);
      cpu_read_1abcd("ar rd");

      // back-to-back reads at WAIT_CYCLES = 1 and 15
      busy_bad = 0;
      p1 = 1'b0; p2 = 1'b0;
      aux_req = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (a1_busy !== !p1) busy_bad++;
         if (a2_busy !== !p2) busy_bad++;
         if (a1_vack || a1_dack || a2_vack || a2_dack) busy_bad++;
         if (!a1_wen || !a2_wen) busy_bad++;
         if (a1_cack) begin
            a1_cyc.push_back(c);
            chk($sformatf("w1 rdata c%0d", c), 32'(a1_rdata), 32'h3C);
         end
         if (a2_cack) begin
            a2_cyc.push_back(c);
            chk($sformatf("w15 rdata c%0d", c), 32'(a2_rdata), 32'hE1);
         end
         p1 = a1_cack;
         p2 = a2_cack;
      end
      aux_req = 1'b0;
      chk("aux busy/ack", 32'(busy_bad), 32'd0);
      chk("w1 addr", 32'(a1_addr), 32'h777);
      chk("w15 addr", 32'(a2_addr), 32'h777);
      chk("w1 ack count", 32'(a1_cyc.size()), 32'd10);
      chk("w1 first", (a1_cyc.size() > 0) ? 32'(a1_cyc[0]) : 32'd0, 32'd3);
      chk("w1 second", (a1_cyc.size() > 1) ? 32'(a1_cyc[1]) : 32'd0, 32'd7);
      chk("w15 ack count", 32'(a2_cyc.size()), 32'd2);
      chk("w15 first", (a2_cyc.size() > 0) ? 32'(a2_cyc[0]) : 32'd0, 32'd17);
      chk("w15 second", (a2_cyc.size() > 1) ? 32'(a2_cyc[1]) : 32'd0, 32'd35);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
